conv_loop_data_out_acc: RTL and testbench
=========================================

Name: conv_loop_data_out_acc

Overview:
- Consumer-side counterpart of the conv input replay loop. The conv engine emits one IMAGE_SIZE plane of per-input-channel products per pass, CHANNEL_NUM_IN planes per output channel.
- This block accumulates those planes pixel-wise in an on-chip plane buffer. It emits the summed plane once per output channel, CHANNEL_NUM_OUT times, then signals completion.

Parameters:
- DATA_WIDTH, 32, pixel/accumulator width (two's complement).
- IMAGE_WIDTH, 64, plane side length; IMAGE_SIZE = IMAGE_WIDTH*IMAGE_WIDTH (must be >= 2).
- CHANNEL_NUM_IN, 256, planes summed per output channel (>= 1).
- CHANNEL_NUM_OUT, 256, output channels produced before done.
- PIX_W, $clog2(IMAGE_SIZE), pixel counter / RAM address width.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high reset.
- valid_in, input, 1, pxl_in carries one valid pixel this cycle (gaps allowed).
- pxl_in, input, DATA_WIDTH, conv engine product for current pixel/plane, raster order.
- pxl_out, output, DATA_WIDTH, accumulated pixel.
- valid_out, output, 1, pxl_out valid this cycle.
- ch_out_idx, output, $clog2(CHANNEL_NUM_OUT)+1, output channel index of the current pxl_out.
- done, output, 1, sticky; all CHANNEL_NUM_OUT planes emitted.

Behaviour:
- Reset: clears pxl_out=0, valid_out=0, ch_out_idx=0, done=0, all counters 0, FSM=FIRST, pipeline valids 0. RAM contents are not cleared and are never relied upon.
- Counters, advanced only on accepted beats (valid_in=1 and FSM!=DONE):
  - pix_cnt: 0..IMAGE_SIZE-1, wraps.
  - in_cnt: 0..CHANNEL_NUM_IN-1, increments on pix wrap.
  - out_cnt: increments on in_cnt wrap.
- FSM states:
  - FIRST (in_cnt==0): RAM[pix_cnt] <= pxl_in, write only, no read.
  - ACCUM (0<in_cnt<CHANNEL_NUM_IN-1): read-modify-write RAM[pix_cnt] += pxl_in.
  - LAST (in_cnt==CHANNEL_NUM_IN-1): emit RAM[pix_cnt]+pxl_in on pxl_out; no RAM write needed.
  - DONE: terminal; reached after the last beat of the last plane of out_cnt==CHANNEL_NUM_OUT-1.
  - If CHANNEL_NUM_IN==1, FIRST and LAST coincide: pxl_out = pxl_in directly, no read.
  - If CHANNEL_NUM_IN==2, ACCUM is skipped.
- Transitions are evaluated on the accepted beat with pix_cnt==IMAGE_SIZE-1: FIRST->ACCUM/LAST; ACCUM->LAST at the in_cnt limit; LAST->FIRST, or LAST->DONE when out_cnt==CHANNEL_NUM_OUT-1.
- Pipeline:
  - Stage 0 (accept cycle): issue synchronous RAM read at pix_cnt; register pxl_in, pix_cnt, mode.
  - Stage 1: sum = rdata + pxl_d, width DATA_WIDTH, wraps modulo 2^DATA_WIDTH, no saturation.
  - ACCUM: write sum to RAM[pix_d] in stage 1.
  - LAST: register sum to pxl_out with valid_out=1.
- Latency: valid_out asserts exactly 2 cycles after the corresponding accepted valid_in beat. Gaps in valid_in propagate as valid_out=0 gaps; order is preserved.
- Hazard: a stage-1 write to address a and a stage-0 read of a+1 (or 0 after wrap) never collide, given IMAGE_SIZE>=2. RAM is simple dual-port: 1 write port, 1 read port.
- ch_out_idx is registered alongside pxl_out and holds its value when valid_out=0.
- done: rises in the same cycle as the final valid_out and stays high until reset.
- valid_in while DONE: ignored; no counter, RAM or output change.
- Reset mid-operation: everything restarts at FIRST. Stale RAM content is overwritten by the next FIRST plane, and no valid_out is generated from pre-reset beats, including beats in flight in the pipeline.

Test Plan:
- Base sum: IMAGE_WIDTH=2, CHANNEL_NUM_IN=3, CHANNEL_NUM_OUT=2, DATA_WIDTH=16; 24 continuous beats of value 1 -> 8 valid_out beats of 3. ch_out_idx is 0,0,0,0,1,1,1,1. Each valid_out comes 2 cycles after its beat; done rises with the 8th output.
- Plane-dependent values: same params, pxl_in = 10*plane + pix (plane 0..2 per output channel) -> outputs 30,33,36,39 per output channel, both channels identical.
- Gapped input: same stimulus as the base sum, with valid_in deasserted randomly ~40% of cycles -> identical output values and order; each valid_out is exactly 2 cycles after its accepted beat.
- Overflow: DATA_WIDTH=8, three planes of 100 -> pxl_out=44 (300 mod 256), no saturation.
- Reset mid-run: reset asserted during plane 1 of output channel 0 -> no valid_out afterwards from old beats; counters 0. A subsequent clean run of all 1s yields 3s with ch_out_idx starting at 0.
- Post-done: after done=1, apply 10 further beats of 5 -> valid_out stays 0, done stays 1, pxl_out unchanged.

Source files
------------

// File: rtl/conv_loop_data_out_acc.sv
// Plane accumulator for the conv output path.
// Sums CHANNEL_NUM_IN consecutive IMAGE_SIZE planes pixel-wise in an on-chip
// plane buffer and streams the summed plane out once per output channel.
// After CHANNEL_NUM_OUT planes have been emitted the block parks in DONE.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_FIRST | first input plane of an output channel: buffer <= pxl_in
// S_ACCUM | middle input planes: buffer <= buffer + pxl_in
// S_LAST  | last input plane: emit buffer + pxl_in, no buffer write
// S_DONE  | all output channels emitted; input beats ignored until reset
//
// With CHANNEL_NUM_IN == 1 the FIRST plane is also the LAST one, so S_FIRST
// emits pxl_in directly and the FSM never leaves S_FIRST until S_DONE.
module conv_loop_data_out_acc #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMAGE_WIDTH     = 64,
  parameter int CHANNEL_NUM_IN  = 256,
  parameter int CHANNEL_NUM_OUT = 256,
  parameter int PIX_W           = $clog2(IMAGE_WIDTH * IMAGE_WIDTH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               valid_in,
  input  logic [DATA_WIDTH-1:0]              pxl_in,
  output logic [DATA_WIDTH-1:0]              pxl_out,
  output logic                               valid_out,
  output logic [$clog2(CHANNEL_NUM_OUT):0]   ch_out_idx,
  output logic                               done
);

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_WIDTH;
  localparam int IN_W       = $clog2(CHANNEL_NUM_IN) + 1;
  localparam int OUT_W      = $clog2(CHANNEL_NUM_OUT) + 1;

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_ACCUM = 2'd1,
    S_LAST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [PIX_W-1:0]        pix_cnt_q, pix_cnt_d;
  logic [IN_W-1:0]         in_cnt_q, in_cnt_d;
  logic [OUT_W-1:0]        out_cnt_q, out_cnt_d;

  logic                    accept;
  logic                    pix_wrap;
  logic                    in_wrap;
  logic                    in_next_last;
  logic                    out_last;
  logic                    mode_first;
  logic                    mode_last;
  logic                    final_beat;

  // stage 1 registers (beat accepted in the previous cycle)
  logic                    s1_vld_q;
  logic                    s1_first_q;
  logic                    s1_last_q;
  logic                    s1_final_q;
  logic [DATA_WIDTH-1:0]   s1_pxl_q;
  logic [PIX_W-1:0]        s1_pix_q;
  logic [OUT_W-1:0]        s1_ch_q;

  logic [DATA_WIDTH-1:0]   mem [IMAGE_SIZE];
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   sum;

  logic [DATA_WIDTH-1:0]   pxl_out_q;
  logic                    valid_out_q;
  logic [OUT_W-1:0]        ch_out_idx_q;
  logic                    done_q;

  assign accept       = valid_in && (state_q != S_DONE);
  assign pix_wrap     = (pix_cnt_q == PIX_W'(IMAGE_SIZE - 1));
  assign in_wrap      = (in_cnt_q == IN_W'(CHANNEL_NUM_IN - 1));
  assign in_next_last = ((in_cnt_q + IN_W'(1)) == IN_W'(CHANNEL_NUM_IN - 1));
  assign out_last     = (out_cnt_q == OUT_W'(CHANNEL_NUM_OUT - 1));
  assign mode_first   = (state_q == S_FIRST);
  assign mode_last    = (state_q == S_LAST) ||
                        ((CHANNEL_NUM_IN == 1) && (state_q == S_FIRST));
  assign final_beat   = accept && pix_wrap && mode_last && out_last;

  // Next-state and counter advance; everything moves only on accepted beats.
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (accept) begin
      pix_cnt_d = pix_wrap ? '0 : pix_cnt_q + PIX_W'(1);
      if (pix_wrap) begin
        in_cnt_d = in_wrap ? '0 : in_cnt_q + IN_W'(1);
        if (in_wrap) begin
          out_cnt_d = out_cnt_q + OUT_W'(1);
        end
        case (state_q)
          S_FIRST: begin
            if (CHANNEL_NUM_IN == 1) begin
              state_d = out_last ? S_DONE : S_FIRST;
            end else if (CHANNEL_NUM_IN == 2) begin
              state_d = S_LAST;
            end else begin
              state_d = S_ACCUM;
            end
          end
          S_ACCUM: begin
            if (in_next_last) begin
              state_d = S_LAST;
            end
          end
          S_LAST: begin
            state_d = out_last ? S_DONE : S_FIRST;
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  // FSM state and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FIRST;
      pix_cnt_q <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Stage 0 -> stage 1: capture the accepted beat and its mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_final_q <= 1'b0;
      s1_pxl_q   <= '0;
      s1_pix_q   <= '0;
      s1_ch_q    <= '0;
    end else begin
      s1_vld_q   <= accept;
      s1_first_q <= mode_first;
      s1_last_q  <= mode_last;
      s1_final_q <= final_beat;
      if (accept) begin
        s1_pxl_q <= pxl_in;
        s1_pix_q <= pix_cnt_q;
        s1_ch_q  <= out_cnt_q;
      end
    end
  end

  // First plane bypasses the (stale) buffer content; otherwise add, wrapping.
  assign sum = s1_first_q ? s1_pxl_q : (rdata_q + s1_pxl_q);

  // Plane buffer: read in stage 0, write back in stage 1. The write address
  // always trails the read address by at least one pixel, so no bypass.
  always_ff @(posedge clk) begin
    if (accept && !mode_first) begin
      rdata_q <= mem[pix_cnt_q];
    end
    if (s1_vld_q && !s1_last_q) begin
      mem[s1_pix_q] <= sum;
    end
  end

  // Output register: emit the summed pixel during the last input plane.
  always_ff @(posedge clk) begin
    if (reset) begin
      pxl_out_q    <= '0;
      valid_out_q  <= 1'b0;
      ch_out_idx_q <= '0;
      done_q       <= 1'b0;
    end else begin
      valid_out_q <= s1_vld_q && s1_last_q;
      if (s1_vld_q && s1_last_q) begin
        pxl_out_q    <= sum;
        ch_out_idx_q <= s1_ch_q;
      end
      if (s1_vld_q && s1_final_q) begin
        done_q <= 1'b1;
      end
    end
  end

  assign pxl_out    = pxl_out_q;
  assign valid_out  = valid_out_q;
  assign ch_out_idx = ch_out_idx_q;
  assign done       = done_q;

endmodule

// File: tb/tb_conv_loop_data_out_acc.sv
// Directed bench for conv_loop_data_out_acc: small 2x2 planes, 3 input
// planes per output channel, 2 output channels; a second 8-bit instance
// covers wrap-around of the sum.
module tb_conv_loop_data_out_acc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid_in;
  logic [15:0] pxl_in;
  logic [15:0] pxl_out;
  logic        valid_out;
  logic [1:0]  ch_out_idx;
  logic        done;

  logic        valid8;
  logic [7:0]  pxl8_in;
  logic [7:0]  pxl8_out;
  logic        vo8;
  logic [0:0]  ch8;
  logic        done8;

  conv_loop_data_out_acc #(
    .DATA_WIDTH(16), .IMAGE_WIDTH(2), .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .pxl_out(pxl_out), .valid_out(valid_out), .ch_out_idx(ch_out_idx), .done(done)
  );

  conv_loop_data_out_acc #(
    .DATA_WIDTH(8), .IMAGE_WIDTH(2), .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(1)
  ) dut8 (
    .clk(clk), .reset(reset), .valid_in(valid8), .pxl_in(pxl8_in),
    .pxl_out(pxl8_out), .valid_out(vo8), .ch_out_idx(ch8), .done(done8)
  );

  typedef struct {
    int val;
    int ch;
    int dn;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_vo = 0;
  int   n8 = 0;
  exp_t e_m;
  int   a_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every valid_out must match the next expected pixel and
  // appear on the edge after the one that accepted its last-plane beat.
  always @(posedge clk) begin
    #1;
    if (valid_out === 1'b1) begin
      n_vo++;
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("extra_vo", {31'd0, valid_out}, 32'd0);
      end else begin
        e_m = exp_q.pop_front();
        a_m = acc_q.pop_front();
        chk("pxl", {16'd0, pxl_out}, e_m.val);
        chk("ch", {30'd0, ch_out_idx}, e_m.ch);
        chk("done_w_out", {31'd0, done}, e_m.dn);
        chk("latency", cyc, a_m + 1);
      end
    end
    if (vo8 === 1'b1) begin
      n8++;
      chk("ovf_pxl", {24'd0, pxl8_out}, 32'd44);
    end
  end

  // acc=1 marks a beat whose output is expected (last plane of a channel).
  task automatic beat(input logic v, input logic [15:0] d, input logic acc);
    @(negedge clk);
    valid_in = v;
    pxl_in   = d;
    if (v && acc) acc_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 16'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    valid_in = 1'b0;
    valid8 = 1'b0;
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_vo  = 0;
  endtask

  // mode 0: all ones; mode 1: 10*plane + pix. gap_pct: chance of an idle cycle.
  task automatic run_all(input int mode, input int gap_pct, input string tag);
    int d;
    for (int oc = 0; oc < 2; oc++)
      for (int p = 0; p < 4; p++)
        exp_q.push_back('{(mode == 1) ? 30 + 3 * p : 3, oc, (oc == 1 && p == 3) ? 1 : 0});
    for (int oc = 0; oc < 2; oc++)
      for (int pl = 0; pl < 3; pl++)
        for (int p = 0; p < 4; p++) begin
          while ($urandom_range(0, 99) < gap_pct) beat(1'b0, 16'd0, 1'b0);
          d = (mode == 1) ? 10 * pl + p : 1;
          beat(1'b1, 16'(d), (pl == 2) ? 1'b1 : 1'b0);
        end
    idle(4);
    chk({tag, "_nout"}, n_vo, 32'd8);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    pxl_in   = '0;
    valid8   = 1'b0;
    pxl8_in  = '0;

    do_reset();
    @(negedge clk);
    chk("rst_vo", {31'd0, valid_out}, 32'd0);
    chk("rst_pxl", {16'd0, pxl_out}, 32'd0);
    chk("rst_ch", {30'd0, ch_out_idx}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    run_all(0, 0, "base");

    n_vo = 0;
    repeat (10) beat(1'b1, 16'd5, 1'b0);
    idle(4);
    chk("pd_nout", n_vo, 32'd0);
    chk("pd_done", {31'd0, done}, 32'd1);
    chk("pd_pxl", {16'd0, pxl_out}, 32'd3);

    do_reset();
    run_all(1, 0, "plane");

    do_reset();
    run_all(0, 40, "gap");

    do_reset();
    for (int p = 0; p < 6; p++) beat(1'b1, 16'd7, 1'b0);
    do_reset();
    idle(3);
    chk("mid_vo", {31'd0, valid_out}, 32'd0);
    chk("mid_pxl", {16'd0, pxl_out}, 32'd0);
    chk("mid_ch", {30'd0, ch_out_idx}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    run_all(0, 0, "after_rst");

    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      valid8  = 1'b1;
      pxl8_in = 8'd100;
    end
    @(negedge clk);
    valid8 = 1'b0;
    idle(4);
    chk("ovf_nout", n8, 32'd4);
    chk("ovf_done", {31'd0, done8}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
